// File: rtl/mcu_led_pio_gen2.sv
// mcu_led_pio_gen2
//   Avalon-MM output PIO driving a WIDTH-bit LED bank. Provides atomic
//   set/clear registers and a prescaled pattern engine (rotate-left,
//   rotate-right, blink). Zero-wait-state slave; reads are combinational.
//
// Optional feature macro: LED_PIO_IRQ_EN
//   Adds the sticky tick flag (STATUS[0], write-1-clear), the irq enable
//   (CTRL[3]) and the level-high irq output.
//
// Ports
//   clk        in   1      system clock
//   reset_n    in   1      asynchronous active-low reset
//   address    in   3      register word address
//   chipselect in   1      slave select
//   write_n    in   1      active-low write strobe
//   writedata  in   32     write data
//   readdata   out  32     read data, combinational, zero-extended
//   out_port   out  WIDTH  LED drive (registered)
//   irq        out  1      interrupt, level-high (LED_PIO_IRQ_EN only)
//
// Register map
//   0 DATA rw, 1 SET wo, 2 CLR wo, 3 CTRL rw, 4 PERIOD rw, 5 STATUS rw1c
module mcu_led_pio_gen2 #(
    parameter int unsigned        WIDTH          = 8,
    parameter int unsigned        PRESC_W        = 24,
    parameter logic [WIDTH-1:0]   RESET_VALUE    = '0,
    parameter logic [PRESC_W-1:0] DEFAULT_PERIOD = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
`ifdef LED_PIO_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLR    = 3'd2;
    localparam logic [2:0] ADDR_CTRL   = 3'd3;
    localparam logic [2:0] ADDR_PERIOD = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_ROTL   = 2'b01,
        MODE_ROTR   = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_t;

    // Register state and next-state
    logic [WIDTH-1:0]   data_q,   data_d;
    mode_t              mode_q,   mode_d;
    logic               run_q,    run_d;
    logic [PRESC_W-1:0] period_q, period_d;
    logic [PRESC_W-1:0] cnt_q,    cnt_d;
    logic               phase_q,  phase_d;
    logic [WIDTH-1:0]   out_d;
    logic               irq_en_q, irq_en_d;
    logic               flag_q,   flag_d;
    logic               irq_d;

    // Bus decode
    logic wr;
    logic wr_data, wr_set, wr_clr, wr_ctrl, wr_period, wr_status;
    logic active, cfg_wr, tick;
    logic [WIDTH-1:0] rotl_val, rotr_val;

    assign wr        = chipselect & ~write_n;
    assign wr_data   = wr && (address == ADDR_DATA);
    assign wr_set    = wr && (address == ADDR_SET);
    assign wr_clr    = wr && (address == ADDR_CLR);
    assign wr_ctrl   = wr && (address == ADDR_CTRL);
    assign wr_period = wr && (address == ADDR_PERIOD);
    assign wr_status = wr && (address == ADDR_STATUS);

    // Shift-based rotates degrade to identity when WIDTH==1
    assign rotl_val = (data_q << 1) | (data_q >> (WIDTH - 1));
    assign rotr_val = (data_q >> 1) | (data_q << (WIDTH - 1));

    assign active = run_q && (mode_q != MODE_STATIC);
    assign cfg_wr = wr_ctrl | wr_period;
    // A config write restarts the prescaler and suppresses that cycle's tick
    assign tick   = active && !cfg_wr && (cnt_q == period_q);

    // Next-state logic
    always_comb begin
        data_d   = data_q;
        mode_d   = mode_q;
        run_d    = run_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        irq_en_d = irq_en_q;
        flag_d   = flag_q;
        out_d    = '0;
        irq_d    = 1'b0;

        // Prescaler
        if (cfg_wr || !active || (cnt_q == period_q)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PRESC_W'(1);
        end

        // Pattern engine
        if (tick) begin
            case (mode_q)
                MODE_ROTL:   data_d  = rotl_val;
                MODE_ROTR:   data_d  = rotr_val;
                MODE_BLINK:  phase_d = ~phase_q;
                default:     data_d  = data_q;
            endcase
        end
        if (!active) begin
            phase_d = 1'b1;
        end

        // CPU writes override any rotation from the same cycle's tick
        if (wr_data) begin
            data_d = writedata[WIDTH-1:0];
        end else if (wr_set) begin
            data_d = data_q | writedata[WIDTH-1:0];
        end else if (wr_clr) begin
            data_d = data_q & ~writedata[WIDTH-1:0];
        end

        if (wr_ctrl) begin
            mode_d = mode_t'(writedata[1:0]);
            run_d  = writedata[2];
`ifdef LED_PIO_IRQ_EN
            irq_en_d = writedata[3];
`endif
        end
        if (wr_period) begin
            period_d = writedata[PRESC_W-1:0];
        end

`ifdef LED_PIO_IRQ_EN
        // Set beats write-1-clear when both land in one cycle
        if (wr_status && writedata[0]) begin
            flag_d = 1'b0;
        end
        if (tick) begin
            flag_d = 1'b1;
        end
`else
        irq_en_d = 1'b0;
        flag_d   = 1'b0;
`endif

        // Outputs registered from next state so they track the registers exactly
        out_d = ((mode_d == MODE_BLINK) && !phase_d) ? '0 : data_d;
        irq_d = flag_d & irq_en_d;
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= RESET_VALUE;
            mode_q   <= MODE_STATIC;
            run_q    <= 1'b0;
            period_q <= DEFAULT_PERIOD;
            cnt_q    <= '0;
            phase_q  <= 1'b1;
            irq_en_q <= 1'b0;
            flag_q   <= 1'b0;
            out_port <= RESET_VALUE;
        end else begin
            data_q   <= data_d;
            mode_q   <= mode_d;
            run_q    <= run_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            irq_en_q <= irq_en_d;
            flag_q   <= flag_d;
            out_port <= out_d;
        end
    end

`ifdef LED_PIO_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_d;
        end
    end
`else
    logic unused_irq;
    assign unused_irq = irq_d;
`endif

    // Read mux, zero latency, independent of chipselect
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = 32'(data_q);
            ADDR_CTRL:   readdata = {28'd0, irq_en_q, run_q, mode_q};
            ADDR_PERIOD: readdata = 32'(period_q);
            ADDR_STATUS: readdata = {31'd0, flag_q};
            default:     readdata = '0;
        endcase
    end

    logic unused_wdata;
    assign unused_wdata = ^writedata;

endmodule
